// File: rtl/fifo_rd_stream_adapter.sv
// fifo_rd_stream_adapter
// Converts a FIFO request/empty read port (1-cycle read latency) into a
// valid/ready stream. A 3-entry prefetch buffer keeps one word per cycle
// flowing while O_RD_REQ depends only on registered state, never on I_READY.
module fifo_rd_stream_adapter #(
    parameter int DW = 32
) (
    input  logic          I_CLK,
    input  logic          I_RST_N,
    input  logic          I_RD_EMPTY,
    output logic          O_RD_REQ,
    input  logic [DW-1:0] I_RD_DATA,
    output logic          O_VALID,
    input  logic          I_READY,
    output logic [DW-1:0] O_DATA,
    output logic [1:0]    O_LEVEL
);

    localparam int DEPTH = 3;

    logic [1:0]    count_q, count_d;
    logic          inflight_q;
    logic [1:0]    head_q, head_d;
    logic [1:0]    tail_q, tail_d;
    logic [2:0]    reserved;
    logic          pop;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] slot_data [DEPTH];

    // Pointer advance modulo the buffer depth (2 wraps to 0).
    function automatic logic [1:0] inc_mod3(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Slots already held plus the word on its way; a request is only issued
    // when that sum leaves a slot free, so the buffer can never overflow.
    assign reserved = {1'b0, count_q} + {2'b00, inflight_q};
    assign O_RD_REQ = I_RST_N && (reserved < 3'd3);
    assign pop      = O_RD_REQ && !I_RD_EMPTY;

    // A word popped last cycle is on I_RD_DATA now and gets captured.
    assign wr_en    = inflight_q;
    assign O_VALID  = (count_q != 2'd0);
    assign rd_en    = O_VALID && I_READY;
    assign O_LEVEL  = count_q;

    // Next-state for occupancy count and head/tail pointers.
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        if (wr_en) begin
            tail_d = inc_mod3(tail_q);
        end
        if (rd_en) begin
            head_d = inc_mod3(head_q);
        end
    end

    // Control registers: in-flight flag, count and pointers.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
            head_q     <= 2'd0;
            tail_q     <= 2'd0;
        end else begin
            inflight_q <= pop;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    // One register per buffer slot; the slot addressed by tail captures the
    // in-flight word. Cleared on reset so O_DATA reads zero while empty.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        localparam logic [1:0] SLOT_IDX = 2'(gi);
        logic [DW-1:0] slot_q;

        // Capture I_RD_DATA into this slot when it is the write target.
        always_ff @(posedge I_CLK or negedge I_RST_N) begin
            if (!I_RST_N) begin
                slot_q <= '0;
            end else if (wr_en && (tail_q == SLOT_IDX)) begin
                slot_q <= I_RD_DATA;
            end
        end

        assign slot_data[gi] = slot_q;
    end

    // Head word straight from storage; no bypass from I_RD_DATA.
    always_comb begin
        O_DATA = '0;
        case (head_q)
            2'd0:    O_DATA = slot_data[0];
            2'd1:    O_DATA = slot_data[1];
            2'd2:    O_DATA = slot_data[2];
            default: O_DATA = '0;
        endcase
    end

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Testbench for fifo_rd_stream_adapter: a behavioural FIFO feeds the adapter,
// every pushed word goes into a scoreboard queue and is popped/compared when
// the stream transfers it. Occupancy and in-flight state are modelled per cycle.
module tb_fifo_rd_stream_adapter;

    localparam int DW = 32;

    logic          I_CLK = 1'b0;
    logic          I_RST_N;
    logic          I_RD_EMPTY;
    logic          O_RD_REQ;
    logic [DW-1:0] I_RD_DATA;
    logic          O_VALID;
    logic          I_READY;
    logic [DW-1:0] O_DATA;
    logic [1:0]    O_LEVEL;

    fifo_rd_stream_adapter #(.DW(DW)) dut (
        .I_CLK      (I_CLK),
        .I_RST_N    (I_RST_N),
        .I_RD_EMPTY (I_RD_EMPTY),
        .O_RD_REQ   (O_RD_REQ),
        .I_RD_DATA  (I_RD_DATA),
        .O_VALID    (O_VALID),
        .I_READY    (I_READY),
        .O_DATA     (O_DATA),
        .O_LEVEL    (O_LEVEL)
    );

    always #5 I_CLK = ~I_CLK;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] fifo_q [$];
    logic [DW-1:0] sb_q   [$];

    int lvl_m;
    bit inflight_m;
    bit bubble;
    int pops, fires, valid_run, max_run, req_drops, tick_n, first_valid_tick;

    task automatic push_word(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        sb_q.push_back(w);
    endtask

    task automatic clear_stats();
        pops = 0; fires = 0; valid_run = 0; max_run = 0;
        req_drops = 0; tick_n = 0; first_valid_tick = -1;
    endtask

    // One clock cycle: drive the FIFO flag, check outputs against the model,
    // score a transfer, advance past the edge and present popped data.
    task automatic tick();
        bit pop;
        bit fire;
        logic [DW-1:0] exp;
        logic [1:0] lvl2;
        I_RD_EMPTY = (fifo_q.size() == 0) || bubble;
        #1;
        lvl2 = lvl_m[1:0];
        tick_n++;
        checks++;
        if (O_LEVEL !== lvl2) begin
            failures++;
            $display("FAIL level tick=%0d got=%0d exp=%0d", tick_n, O_LEVEL, lvl2);
        end
        checks++;
        if (lvl_m + int'(inflight_m) > 3) begin
            failures++;
            $display("FAIL invariant tick=%0d count=%0d inflight=%0d", tick_n, lvl_m, inflight_m);
        end
        checks++;
        if (O_VALID !== (lvl_m != 0)) begin
            failures++;
            $display("FAIL valid tick=%0d got=%b exp=%b", tick_n, O_VALID, (lvl_m != 0));
        end
        checks++;
        if (O_RD_REQ !== ((lvl_m + int'(inflight_m)) < 3)) begin
            failures++;
            $display("FAIL rd_req tick=%0d got=%b exp=%b", tick_n, O_RD_REQ, ((lvl_m + int'(inflight_m)) < 3));
        end
        if (fifo_q.size() != 0 && O_RD_REQ !== 1'b1) req_drops++;
        pop  = (O_RD_REQ === 1'b1) && !I_RD_EMPTY;
        fire = (O_VALID === 1'b1) && I_READY;
        if (O_VALID === 1'b1) begin
            valid_run++;
            if (first_valid_tick < 0) first_valid_tick = tick_n;
            if (valid_run > max_run) max_run = valid_run;
        end else begin
            valid_run = 0;
        end
        if (fire) begin
            fires++;
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL spurious_word tick=%0d got=%h exp=none", tick_n, O_DATA);
            end else begin
                exp = sb_q.pop_front();
                if (O_DATA !== exp) begin
                    failures++;
                    $display("FAIL order tick=%0d got=%h exp=%h", tick_n, O_DATA, exp);
                end
            end
        end
        @(posedge I_CLK);
        #1;
        lvl_m = lvl_m + (inflight_m ? 1 : 0) - (fire ? 1 : 0);
        inflight_m = pop;
        if (pop) begin
            pops++;
            I_RD_DATA = fifo_q.pop_front();
        end else begin
            I_RD_DATA = $urandom();
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        I_READY = 1'b1;
        bubble  = 1'b0;
        while ((sb_q.size() != 0 || lvl_m != 0 || inflight_m) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (sb_q.size() != 0 || lvl_m != 0) begin
            failures++;
            $display("FAIL drain_timeout left=%0d level=%0d exp_left=0", sb_q.size(), lvl_m);
        end
    endtask

    task automatic test_reset();
        I_RST_N = 1'b0; I_READY = 1'b0; I_RD_EMPTY = 1'b1; I_RD_DATA = '0;
        bubble = 1'b0; lvl_m = 0; inflight_m = 1'b0;
        #1;
        checks++;
        if ({O_VALID, O_RD_REQ, O_LEVEL, O_DATA} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got v=%b req=%b lvl=%0d d=%h exp all zero", O_VALID, O_RD_REQ, O_LEVEL, O_DATA);
        end
        @(posedge I_CLK); @(posedge I_CLK); #1;
        I_RST_N = 1'b1;
        #1;
        checks++;
        if (O_RD_REQ !== 1'b1) begin
            failures++;
            $display("FAIL req_after_reset got=%b exp=1", O_RD_REQ);
        end
        $display("test_reset done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_single();
        clear_stats();
        push_word(32'hA5A50001);
        I_READY = 1'b1;
        repeat (6) tick();
        checks++;
        if (pops != 1) begin failures++; $display("FAIL single_pops got=%0d exp=1", pops); end
        checks++;
        if (first_valid_tick != 3) begin failures++; $display("FAIL single_latency got=%0d exp=3", first_valid_tick); end
        checks++;
        if (max_run != 1 || fires != 1) begin failures++; $display("FAIL single_valid_len got=%0d/%0d exp=1/1", max_run, fires); end
        checks++;
        if (O_LEVEL !== 2'd0) begin failures++; $display("FAIL single_level_end got=%0d exp=0", O_LEVEL); end
        $display("test_single done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_streaming();
        int n;
        clear_stats();
        for (int i = 0; i < 16; i++) push_word(DW'(i));
        I_READY = 1'b1;
        n = 0;
        while (sb_q.size() != 0 && n < 40) begin tick(); n++; end
        checks++;
        if (sb_q.size() != 0) begin failures++; $display("FAIL stream_timeout left=%0d exp=0", sb_q.size()); end
        checks++;
        if (max_run != 16) begin failures++; $display("FAIL stream_run got=%0d exp=16", max_run); end
        checks++;
        if (req_drops != 0) begin failures++; $display("FAIL stream_req_drop got=%0d exp=0", req_drops); end
        drain(10);
        $display("test_streaming done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_backpressure();
        clear_stats();
        I_READY = 1'b0;
        for (int i = 0; i < 8; i++) push_word(DW'(32'h10 + i));
        repeat (10) tick();
        checks++;
        if (pops != 3) begin failures++; $display("FAIL bp_pops got=%0d exp=3", pops); end
        checks++;
        if (O_LEVEL !== 2'd3) begin failures++; $display("FAIL bp_level got=%0d exp=3", O_LEVEL); end
        checks++;
        if (O_RD_REQ !== 1'b0) begin failures++; $display("FAIL bp_req got=%b exp=0", O_RD_REQ); end
        checks++;
        if (O_DATA !== 32'h10) begin failures++; $display("FAIL bp_head got=%h exp=00000010", O_DATA); end
        drain(40);
        checks++;
        if (fires != 8) begin failures++; $display("FAIL bp_delivered got=%0d exp=8", fires); end
        $display("test_backpressure done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_bubbles();
        int n;
        clear_stats();
        for (int i = 0; i < 40; i++) push_word(32'h1000 + DW'(i));
        n = 0;
        while (fifo_q.size() != 0 && n < 400) begin
            bubble  = ~bubble;
            I_READY = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        drain(40);
        checks++;
        if (fires != 40) begin failures++; $display("FAIL bubbles_delivered got=%0d exp=40", fires); end
        $display("test_bubbles done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_stall();
        logic [DW-1:0] held;
        logic [1:0]    lvl0;
        clear_stats();
        I_READY = 1'b0;
        push_word(32'hBEEF0001);
        repeat (3) tick();
        checks++;
        if (O_VALID !== 1'b1) begin failures++; $display("FAIL stall_valid got=%b exp=1", O_VALID); end
        held = O_DATA;
        lvl0 = O_LEVEL;
        push_word(32'hBEEF0002);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (O_DATA !== held || O_VALID !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold cycle=%0d got=%h/%b exp=%h/1", i, O_DATA, O_VALID, held);
            end
        end
        checks++;
        if (O_LEVEL !== lvl0 + 2'd1) begin failures++; $display("FAIL stall_level got=%0d exp=%0d", O_LEVEL, lvl0 + 2'd1); end
        drain(20);
        checks++;
        if (fires != 2) begin failures++; $display("FAIL stall_delivered got=%0d exp=2", fires); end
        $display("test_stall done checks=%0d failures=%0d", checks, failures);
    endtask

    task automatic test_reset_mid();
        clear_stats();
        I_READY = 1'b0;
        for (int i = 0; i < 8; i++) push_word(32'h5500 + DW'(i));
        repeat (3) tick();
        checks++;
        if (O_LEVEL !== 2'd2) begin failures++; $display("FAIL mid_setup_level got=%0d exp=2", O_LEVEL); end
        I_RST_N = 1'b0;
        #1;
        checks++;
        if ({O_VALID, O_RD_REQ, O_LEVEL, O_DATA} !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs got v=%b req=%b lvl=%0d d=%h exp all zero", O_VALID, O_RD_REQ, O_LEVEL, O_DATA);
        end
        fifo_q.delete(); sb_q.delete();
        lvl_m = 0; inflight_m = 1'b0;
        @(posedge I_CLK); #1;
        I_RST_N = 1'b1;
        I_RD_DATA = '0;
        #1;
        checks++;
        if (O_RD_REQ !== 1'b1) begin failures++; $display("FAIL mid_req_after_release got=%b exp=1", O_RD_REQ); end
        clear_stats();
        push_word(32'h77770001);
        drain(10);
        checks++;
        if (fires != 1) begin failures++; $display("FAIL mid_post_reset_word got=%0d exp=1", fires); end
        $display("test_reset_mid done checks=%0d failures=%0d", checks, failures);
    endtask

    initial begin
        test_reset();
        test_single();
        test_streaming();
        test_backpressure();
        test_bubbles();
        test_stall();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream_adapter.md
# fifo_rd_stream_adapter

Single-clock adapter on the read side of the FIFO. It turns the FIFO's request/empty read port, which has 1-cycle read latency, into a valid/ready stream for downstream logic. A 3-entry prefetch buffer lets the stream run at one word per cycle without any combinational path from I_READY to O_RD_REQ. It sits directly downstream of the FIFO read port, in the read clock domain.

## Interface

- DW, 32, data width in bits; must match the FIFO data width.

- I_CLK  input  1  read-domain clock; all state on the rising edge.
- I_RST_N  input  1  asynchronous, active-low reset.
- I_RD_EMPTY  input  1  FIFO empty flag.
- O_RD_REQ  output  1  read request to the FIFO.
- I_RD_DATA  input  DW  FIFO read data; valid the cycle after an accepted pop.
- O_VALID  output  1  stream data valid.
- I_READY  input  1  downstream ready.
- O_DATA  output  DW  stream data.
- O_LEVEL  output  2  words currently held in the buffer (0..3).

## Operation

- Pop: w_pop = O_RD_REQ && !I_RD_EMPTY. A pop is a FIFO read at that rising edge.
- In-flight flag: r_inflight <= w_pop on every edge. r_inflight=1 means I_RD_DATA carries a popped word during the current cycle.
- Write: when r_inflight=1, the next edge stores I_RD_DATA at the tail.
  - tail increments mod 3 (2 wraps to 0).
- Read: O_VALID && I_READY at an edge removes the head word.
  - head increments mod 3.
- Count r_count, 0..3:
  - +1 on write only.
  - -1 on read only.
  - unchanged on simultaneous write and read.
- O_RD_REQ = I_RST_N && (r_count + r_inflight < 3).
  - Depends only on registers (plus reset), never on I_READY.
  - Reservation rule: a word is requested only when a buffer slot is guaranteed for it.
- Invariant: r_count + r_inflight <= 3 at all times. This makes overflow impossible; the bench asserts it.
- O_VALID = (r_count != 0).
- O_DATA = storage[head]. No bypass: a word written at edge N is first visible after edge N, never combinationally from I_RD_DATA.
- O_LEVEL = r_count.
- Stream rules:
  - While O_VALID && !I_READY, O_DATA and O_VALID hold stable.
  - O_VALID never deasserts without a transfer.
  - I_READY is allowed high while O_VALID=0; it has no effect then.
- Words leave in exactly the order they were popped. No loss, no duplication.
- I_RD_DATA is ignored whenever r_inflight=0.

## Timing

- Reset (I_RST_N low, asynchronous):
  - r_count=0, r_inflight=0, head=0, tail=0, storage=0.
  - O_VALID=0, O_DATA=0, O_LEVEL=0, O_RD_REQ=0.
- First cycle after reset release: O_RD_REQ=1.
- Latency from FIFO non-empty to stream, with the adapter empty:
  - pop at edge E.
  - capture at E+1.
  - O_VALID=1 in the cycle after E+1.
  - 2 edges total.
- Throughput:
  - Steady state with I_READY=1 and FIFO non-empty: r_count=1, r_inflight=1, O_RD_REQ=1.
  - One word per cycle.
- Backpressure: with I_READY=0 the adapter stops requesting once it holds 3 words.
  - at most 3 pops after I_READY falls while the adapter is empty.
  - O_LEVEL=3 and O_RD_REQ=0 until a transfer.
- Empty FIFO: O_RD_REQ may stay high. With I_RD_EMPTY=1 no pop occurs and r_inflight stays 0.
- Reset mid-operation: buffered words and any in-flight word are discarded. The FIFO must be reset in the same event; this is a system requirement, not checked here.

## Test plan

- Reset: assert I_RST_N low mid-traffic with O_LEVEL=2 and r_inflight=1 -> immediately O_VALID=0, O_LEVEL=0, O_DATA=0, O_RD_REQ=0; after release, O_RD_REQ=1 in the first cycle.
- Single word: FIFO holds 0xA5A50001, I_READY=1 -> pop at edge 1, O_VALID=1 with O_DATA=0xA5A50001 for exactly one cycle after edge 2, then O_LEVEL=0.
- Streaming: words 0..15 back-to-back, I_READY=1 -> O_VALID high for 16 consecutive cycles carrying 0..15 in order; O_RD_REQ never drops while the FIFO is non-empty.
- Backpressure: I_READY=0, FIFO holds 0x10..0x17 -> exactly 3 pops, O_LEVEL=3, O_RD_REQ=0, O_DATA held at 0x10; raise I_READY -> 0x10..0x17 delivered in order, none lost or duplicated.
- Bubbles and wrap: I_RD_EMPTY toggles every cycle and I_READY is random, 40 words -> no spurious O_VALID, head/tail wrap past 2 repeatedly, output order matches input, invariant r_count+r_inflight<=3 holds every cycle.
- Stall on head: O_VALID=1 and I_READY=0 for 5 cycles while a pop lands -> O_DATA unchanged, O_LEVEL increments by 1.
